mod_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one fixed-latency modular arithmetic unit (modular multiplier or add/sub stage) between two requesters, A and B. It registers the winning operand pair onto the shared unit's inputs and drives the unit's 2:1 operand-select line. It tracks every issued operation through the unit's latency with a tag pipeline and returns each result to the requester that issued it. It sits between the butterfly/twiddle-generation front ends and the shared modular datapath of the FFT core.

---
 rtl/mod_share_arb.sv | 137 +++++++++++++
 tb/tb_mod_share_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_share_arb.sv
// Round-robin arbiter sharing one fixed-latency modular arithmetic unit between requesters A and B.
// Winner's operands are registered onto the unit; a {valid, sel} tag pipeline routes each result back.
module mod_share_arb #(
    parameter int P_WIDTH = 64,
    parameter int MUL_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               a_req_valid,
    output logic               a_req_ready,
    input  logic [P_WIDTH-1:0] a_op0,
    input  logic [P_WIDTH-1:0] a_op1,
    input  logic               b_req_valid,
    output logic               b_req_ready,
    input  logic [P_WIDTH-1:0] b_op0,
    input  logic [P_WIDTH-1:0] b_op1,
    output logic               mul_valid,
    output logic               mul_sel,
    output logic [P_WIDTH-1:0] mul_op0,
    output logic [P_WIDTH-1:0] mul_op1,
    input  logic [P_WIDTH-1:0] mul_res,
    output logic               a_rsp_valid,
    output logic [P_WIDTH-1:0] a_rsp_data,
    output logic               b_rsp_valid,
    output logic [P_WIDTH-1:0] b_rsp_data,
    output logic               idle
);

    logic               grant_a;
    logic               grant_b;
    logic               prio_a_reg;
    logic               mul_valid_reg;
    logic               mul_sel_reg;
    logic [P_WIDTH-1:0] mul_op0_reg;
    logic [P_WIDTH-1:0] mul_op1_reg;
    logic [MUL_LAT-1:0] tag_valid_reg;
    logic [MUL_LAT-1:0] tag_sel_reg;
    logic [MUL_LAT-1:0] tag_valid_next;
    logic [MUL_LAT-1:0] tag_sel_next;
    logic               a_rsp_valid_reg;
    logic               b_rsp_valid_reg;
    logic [P_WIDTH-1:0] a_rsp_data_reg;
    logic [P_WIDTH-1:0] b_rsp_data_reg;
    logic               tag_last_valid;
    logic               tag_last_sel;

    // Grants are gated by rst so nothing is accepted while the datapath is being cleared.
    always_comb begin
        grant_a = ~rst & ~hold & a_req_valid & (~b_req_valid | prio_a_reg);
        grant_b = ~rst & ~hold & b_req_valid & (~a_req_valid | ~prio_a_reg);
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_a_reg <= 1'b1;
        end else if (grant_a) begin
            prio_a_reg <= 1'b0;
        end else if (grant_b) begin
            prio_a_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_valid_reg <= 1'b0;
            mul_sel_reg   <= 1'b0;
            mul_op0_reg   <= '0;
            mul_op1_reg   <= '0;
        end else begin
            mul_valid_reg <= grant_a | grant_b;
            if (grant_a | grant_b) begin
                mul_sel_reg <= grant_a;
                mul_op0_reg <= grant_a ? a_op0 : b_op0;
                mul_op1_reg <= grant_a ? a_op1 : b_op1;
            end
        end
    end

    // Stage 0 follows the issue register; the last stage lines up with mul_res.
    generate
        for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_first
                assign tag_valid_next[gi] = mul_valid_reg;
                assign tag_sel_next[gi]   = mul_sel_reg;
            end else begin : g_rest
                assign tag_valid_next[gi] = tag_valid_reg[gi-1];
                assign tag_sel_next[gi]   = tag_sel_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_reg <= '0;
            tag_sel_reg   <= '0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_sel_reg   <= tag_sel_next;
        end
    end

    assign tag_last_valid = tag_valid_reg[MUL_LAT-1];
    assign tag_last_sel   = tag_sel_reg[MUL_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rsp_valid_reg <= 1'b0;
            b_rsp_valid_reg <= 1'b0;
            a_rsp_data_reg  <= '0;
            b_rsp_data_reg  <= '0;
        end else begin
            a_rsp_valid_reg <= tag_last_valid & tag_last_sel;
            b_rsp_valid_reg <= tag_last_valid & ~tag_last_sel;
            if (tag_last_valid & tag_last_sel) begin
                a_rsp_data_reg <= mul_res;
            end
            if (tag_last_valid & ~tag_last_sel) begin
                b_rsp_data_reg <= mul_res;
            end
        end
    end

    assign mul_valid   = mul_valid_reg;
    assign mul_sel     = mul_sel_reg;
    assign mul_op0     = mul_op0_reg;
    assign mul_op1     = mul_op1_reg;
    assign a_rsp_valid = a_rsp_valid_reg;
    assign b_rsp_valid = b_rsp_valid_reg;
    assign a_rsp_data  = a_rsp_data_reg;
    assign b_rsp_data  = b_rsp_data_reg;
    assign idle        = ~mul_valid_reg & ~(|tag_valid_reg);

endmodule

// File: tb/tb_mod_share_arb.sv
// Bench for mod_share_arb: a delay-line multiplier stands in for the shared unit, and a
// queue-based scoreboard predicts grants, issue, responses and idle from the arbitration rules.
module tb_mod_share_arb;

    localparam int W   = 64;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst, hold;
    logic         a_req_valid, b_req_valid;
    logic         a_req_ready, b_req_ready;
    logic [W-1:0] a_op0, a_op1, b_op0, b_op1;
    logic         mul_valid, mul_sel;
    logic [W-1:0] mul_op0, mul_op1, mul_res;
    logic         a_rsp_valid, b_rsp_valid;
    logic [W-1:0] a_rsp_data, b_rsp_data;
    logic         idle;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    mod_share_arb #(.P_WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_op0(a_op0), .a_op1(a_op1),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_op0(b_op0), .b_op1(b_op1),
        .mul_valid(mul_valid), .mul_sel(mul_sel), .mul_op0(mul_op0), .mul_op1(mul_op1),
        .mul_res(mul_res),
        .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared unit: product of the issued operands appears exactly LAT cycles after mul_valid.
    logic [W-1:0] unit_pipe [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) unit_pipe[i] <= unit_pipe[i-1];
        unit_pipe[0] <= mul_valid ? mul_op0 * mul_op1 : 64'hBAD0_BAD0_BAD0_BAD0;
    end
    assign mul_res = unit_pipe[LAT-1];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] r64();
        return {$urandom, $urandom};
    endfunction

    // Scoreboard: each accepted op becomes an expected response due LAT+2 cycles later.
    typedef struct {
        bit           sel;
        logic [W-1:0] data;
        int           due;
    } ent_t;
    ent_t         sb_q[$];
    bit           m_prio = 1'b1;
    bit           m_mv = 1'b0, m_sel = 1'b0;
    logic [W-1:0] m_op0 = '0, m_op1 = '0, m_adata = '0, m_bdata = '0;
    bit           sb_ga, sb_gb, sb_ar, sb_br;
    logic [W-1:0] sb_prod;
    ent_t         sb_e;

    always @(negedge clk) begin
        if (chk_en) begin
            sb_ga = !rst && !hold && a_req_valid && (!b_req_valid || m_prio);
            sb_gb = !rst && !hold && b_req_valid && (!a_req_valid || !m_prio);
            chk("sb_a_ready", a_req_ready, sb_ga);
            chk("sb_b_ready", b_req_ready, sb_gb);
            chk("sb_mul_valid", mul_valid, m_mv);
            chk("sb_mul_sel", mul_sel, m_sel);
            chk("sb_mul_op0", mul_op0, m_op0);
            chk("sb_mul_op1", mul_op1, m_op1);
            sb_ar = 1'b0;
            sb_br = 1'b0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                sb_e = sb_q.pop_front();
                if (sb_e.sel) begin sb_ar = 1'b1; m_adata = sb_e.data; end
                else begin sb_br = 1'b1; m_bdata = sb_e.data; end
                $display("rsp %s expected data=%h at cycle %0d", sb_e.sel ? "A" : "B", sb_e.data, cyc);
            end
            chk("sb_a_rsp_valid", a_rsp_valid, sb_ar);
            chk("sb_b_rsp_valid", b_rsp_valid, sb_br);
            chk("sb_a_rsp_data", a_rsp_data, m_adata);
            chk("sb_b_rsp_data", b_rsp_data, m_bdata);
            chk("sb_idle", idle, sb_q.size() == 0);
            if (rst) begin
                sb_q.delete();
                m_prio = 1'b1; m_mv = 1'b0; m_sel = 1'b0;
                m_op0 = '0; m_op1 = '0; m_adata = '0; m_bdata = '0;
            end else begin
                m_mv = sb_ga | sb_gb;
                if (sb_ga) begin
                    sb_prod = a_op0 * a_op1;
                    sb_q.push_back('{1'b1, sb_prod, cyc + LAT + 2});
                    m_prio = 1'b0; m_sel = 1'b1; m_op0 = a_op0; m_op1 = a_op1;
                end else if (sb_gb) begin
                    sb_prod = b_op0 * b_op1;
                    sb_q.push_back('{1'b0, sb_prod, cyc + LAT + 2});
                    m_prio = 1'b1; m_sel = 1'b0; m_op0 = b_op0; m_op1 = b_op1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_req_valid = 1'b0; b_req_valid = 1'b0; hold = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit av, bv, hd;
        bit exp_ar, exp_br;
    } vec_t;
    vec_t tbl[12];

    int  a_cnt, b_cnt, strobes;
    bit  a_acc, b_acc, seen_b;

    initial begin
        rst = 1'b1; hold = 1'b0;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        a_op0 = '0; a_op1 = '0; b_op0 = '0; b_op1 = '0;

        // Priority/hold table starting from the reset pointer (A wins first tie).
        tbl[0]  = '{1, 1, 0, 1, 0};
        tbl[1]  = '{1, 1, 0, 0, 1};
        tbl[2]  = '{1, 1, 1, 0, 0};
        tbl[3]  = '{1, 1, 1, 0, 0};
        tbl[4]  = '{1, 1, 1, 0, 0};
        tbl[5]  = '{1, 1, 0, 1, 0};
        tbl[6]  = '{1, 1, 0, 0, 1};
        tbl[7]  = '{0, 1, 0, 0, 1};
        tbl[8]  = '{1, 0, 0, 1, 0};
        tbl[9]  = '{1, 1, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0};
        tbl[11] = '{1, 1, 0, 1, 0};

        tick();
        chk_en = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset/idle: no strobes and idle for 20 cycles.
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mul_valid || a_rsp_valid || b_rsp_valid || !idle) strobes++;
            tick();
        end
        chk("idle_no_strobes", strobes, 0);

        // Single A op: 5*7 returns as 0x23 six cycles after the grant.
        a_req_valid = 1'b1; a_op0 = 64'h5; a_op1 = 64'h7;
        @(negedge clk);
        chk("single_a_ready", a_req_ready, 1'b1);
        tick();
        a_req_valid = 1'b0;
        seen_b = 1'b0; a_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("single_mul_valid", mul_valid, 1'b1);
                chk("single_mul_sel", mul_sel, 1'b1);
            end
            if (k == 6) begin
                chk("single_a_rsp_valid", a_rsp_valid, 1'b1);
                chk("single_a_rsp_data", a_rsp_data, 64'h23);
            end
            if (a_rsp_valid) a_cnt++;
            if (b_rsp_valid) seen_b = 1'b1;
            tick();
        end
        chk("single_a_rsp_count", a_cnt, 1);
        chk("single_no_b_rsp", seen_b, 1'b0);

        // Table-driven priority and hold vectors.
        do_reset();
        a_op0 = r64(); a_op1 = r64(); b_op0 = r64(); b_op1 = r64();
        for (int i = 0; i < 12; i++) begin
            a_req_valid = tbl[i].av; b_req_valid = tbl[i].bv; hold = tbl[i].hd;
            @(negedge clk);
            chk($sformatf("tbl%0d_a_ready", i), a_req_ready, tbl[i].exp_ar);
            chk($sformatf("tbl%0d_b_ready", i), b_req_ready, tbl[i].exp_br);
            a_acc = a_req_valid & a_req_ready;
            b_acc = b_req_valid & b_req_ready;
            tick();
            if (a_acc) begin a_op0 = r64(); a_op1 = r64(); end
            if (b_acc) begin b_op0 = r64(); b_op1 = r64(); end
        end
        a_req_valid = 1'b0; b_req_valid = 1'b0; hold = 1'b0;
        repeat (10) tick();

        // Contention: strict alternation A,B,... and 4 responses each.
        do_reset();
        a_req_valid = 1'b1; b_req_valid = 1'b1;
        a_cnt = 0; b_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i < 8) begin
                chk($sformatf("cont%0d_a_ready", i), a_req_ready, (i % 2) == 0);
                chk($sformatf("cont%0d_b_ready", i), b_req_ready, (i % 2) == 1);
            end
            if (a_rsp_valid) a_cnt++;
            if (b_rsp_valid) b_cnt++;
            a_acc = a_req_valid & a_req_ready;
            b_acc = b_req_valid & b_req_ready;
            tick();
            if (a_acc) begin a_op0 = r64(); a_op1 = r64(); end
            if (b_acc) begin b_op0 = r64(); b_op1 = r64(); end
            if (i == 7) begin a_req_valid = 1'b0; b_req_valid = 1'b0; end
        end
        chk("cont_a_rsp_count", a_cnt, 4);
        chk("cont_b_rsp_count", b_cnt, 4);

        // Back-to-back B only: ready every cycle, 10 responses.
        b_req_valid = 1'b1; b_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i < 10) chk($sformatf("b2b%0d_b_ready", i), b_req_ready, 1'b1);
            if (b_rsp_valid) b_cnt++;
            tick();
            b_op0 = r64(); b_op1 = r64();
            if (i == 9) b_req_valid = 1'b0;
        end
        chk("b2b_rsp_count", b_cnt, 10);

        // Reset mid-flight: three A ops discarded; rst with A valid grants nothing.
        do_reset();
        a_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rmf%0d_a_ready", i), a_req_ready, 1'b1);
            tick();
            a_op0 = r64(); a_op1 = r64();
        end
        a_req_valid = 1'b0;
        tick();
        rst = 1'b1; a_req_valid = 1'b1;
        @(negedge clk);
        chk("rmf_rst_a_ready", a_req_ready, 1'b0);
        tick();
        rst = 1'b0; a_req_valid = 1'b0;
        @(negedge clk);
        chk("rmf_idle_after_rst", idle, 1'b1);
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            if (a_rsp_valid || b_rsp_valid) strobes++;
            tick();
            @(negedge clk);
        end
        chk("rmf_no_rsp", strobes, 0);
        tick();

        // Randomized traffic with occasional hold and reset, checked by the scoreboard.
        do_reset();
        a_acc = 1'b0; b_acc = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            hold = ($urandom_range(0, 99) < 15);
            if (!a_req_valid || a_acc) begin
                a_req_valid = ($urandom_range(0, 99) < 60);
                a_op0 = r64(); a_op1 = r64();
            end
            if (!b_req_valid || b_acc) begin
                b_req_valid = ($urandom_range(0, 99) < 60);
                b_op0 = r64(); b_op1 = r64();
            end
            @(negedge clk);
            a_acc = a_req_valid & a_req_ready;
            b_acc = b_req_valid & b_req_ready;
            tick();
        end
        rst = 1'b0; hold = 1'b0; a_req_valid = 1'b0; b_req_valid = 1'b0;
        repeat (20) tick();
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
